sym_fir_filt_param: RTL and testbench

//  Parametrised, fully pipelined symmetric (linear-phase) FIR filter with run-time loadable coefficients.
//  - Coefficients sit in double-buffered banks.
//  - A sample-valid handshake supports sub-rate operation.
//  - Data/coef masks are kept for precision-reduction experiments; the output saturates.
//  - Sits between the upsampler and the DAC/channel model in the transmit chain; also usable as the receive matched filter.

---
 rtl/fir_pkg.sv | 29 ++
 rtl/fir_adder_tree.sv | 59 +++++
 rtl/sym_fir_filt_param.sv | 180 ++++++++++++++++++
 tb/tb_sym_fir_filt_param.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared helpers and constants for the symmetric FIR filter family.
package fir_pkg;

    function automatic int fir_clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int fir_tree_w(input int data_w, input int guard_w);
        return data_w + guard_w;
    endfunction

    function automatic int fir_lat(input int num_unique);
        return 4 + fir_clog2(num_unique);
    endfunction

    localparam int FIR_BRICK_UNIQUE = 16;

    // Default 31-tap brick-wall set, Q1.17, index 0 = outer tap, 15 = centre
    localparam logic signed [17:0] FIR_BRICK_COEF [FIR_BRICK_UNIQUE] = '{
        -18'sd3566,  -18'sd5404,  -18'sd4114,  18'sd0,
         18'sd4300,   18'sd7800,   18'sd6900,  18'sd0,
        -18'sd10100, -18'sd16400, -18'sd13300, 18'sd0,
         18'sd20200,  18'sd39800,  18'sd53488, 18'sd59411
    };

endpackage

// File: rtl/fir_adder_tree.sv
// Registered pairwise adder tree with a travelling valid bit; the input register
// is the first stage. Width grows one bit per level so no level can wrap. N >= 2.
module fir_adder_tree
    import fir_pkg::*;
#(
    parameter int N = 16,
    parameter int W = 22,
    localparam int L  = fir_clog2(N),
    localparam int WO = W + L
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           in_vld,
    input  logic [N*W-1:0] din,
    input  logic [W-1:0]   data_mask,
    output logic           out_vld,
    output logic [WO-1:0]  dout
);

    localparam int NP = 1 << L;

    logic signed [WO-1:0] lvl [L+1][NP];
    logic        [L:0]    vld;
    logic signed [WO-1:0] mask_x;

    // Sign-extend the mask so all-ones stays all-ones at the grown width
    assign mask_x = WO'($signed(data_mask));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld <= '0;
            for (int l = 0; l <= L; l++)
                for (int j = 0; j < NP; j++)
                    lvl[l][j] <= '0;
        end else begin
            vld <= {vld[L-1:0], in_vld};
            if (in_vld) begin
                for (int j = 0; j < N; j++)
                    lvl[0][j] <= WO'($signed(din[j*W +: W]));
                for (int j = N; j < NP; j++)
                    lvl[0][j] <= '0;
            end
            for (int l = 1; l <= L; l++) begin
                if (vld[l-1]) begin
                    for (int j = 0; j < (NP >> l); j++) begin
                        if (l == 1)
                            lvl[l][j] <= (lvl[l-1][2*j] + lvl[l-1][2*j+1]) & mask_x;
                        else
                            lvl[l][j] <= lvl[l-1][2*j] + lvl[l-1][2*j+1];
                    end
                end
            end
        end
    end

    assign out_vld = vld[L];
    assign dout    = lvl[L][0];

endmodule

// File: rtl/sym_fir_filt_param.sv
// Pipelined symmetric FIR: delay line, pre-add, multiply, scale, adder tree,
// saturating output, with double-buffered run-time coefficient banks.
module sym_fir_filt_param
    import fir_pkg::*;
#(
    parameter int NUM_TAPS = 31,
    parameter int DATA_W   = 18,
    parameter int COEF_W   = 18,
    parameter int GUARD_W  = 4,
    localparam int NUM_UNIQUE = (NUM_TAPS + 1) / 2,
    localparam int TREE_W     = fir_tree_w(DATA_W, GUARD_W),
    localparam int ADDR_W     = fir_clog2(NUM_UNIQUE)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] x_in,
    input  logic [TREE_W-1:0] data_mask,
    input  logic [COEF_W-1:0] coef_mask,
    input  logic              coef_we,
    input  logic [ADDR_W-1:0] coef_addr,
    input  logic [COEF_W-1:0] coef_wdata,
    input  logic              coef_commit,
    output logic              coef_busy,
    output logic              out_valid,
    output logic [DATA_W-1:0] y,
    output logic              sat_flag
);

    localparam int CENTRE = NUM_UNIQUE - 1;
    localparam int P_W    = DATA_W + 1;
    localparam int PROD_W = P_W + COEF_W;
    localparam int SUM_W  = TREE_W + fir_clog2(NUM_UNIQUE);

    localparam logic signed [SUM_W-1:0] Y_MAX = SUM_W'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [SUM_W-1:0] Y_MIN = SUM_W'(-(2 ** (DATA_W - 1)));

    function automatic logic signed [TREE_W-1:0] scale_narrow(input logic signed [PROD_W-1:0] m);
        return TREE_W'(m >>> (COEF_W - 1));
    endfunction

    function automatic logic is_sat(input logic signed [SUM_W-1:0] s);
        return (s > Y_MAX) || (s < Y_MIN);
    endfunction

    function automatic logic [DATA_W-1:0] sat_out(input logic signed [SUM_W-1:0] s);
        if (s > Y_MAX) return DATA_W'(Y_MAX);
        if (s < Y_MIN) return DATA_W'(Y_MIN);
        return DATA_W'(s);
    endfunction

    logic signed [DATA_W-1:0] x_p0 [NUM_TAPS];
    logic                     vld_p0;
    logic signed [P_W-1:0]    p_p1 [NUM_UNIQUE];
    logic                     vld_p1;
    logic signed [PROD_W-1:0] m_p2 [NUM_UNIQUE];
    logic                     vld_p2;

    logic signed [COEF_W-1:0] bank0 [NUM_UNIQUE];
    logic signed [COEF_W-1:0] bank1 [NUM_UNIQUE];
    logic                     bank_sel;
    logic signed [COEF_W-1:0] coef_eff [NUM_UNIQUE];
    logic                     addr_ok;

    logic [NUM_UNIQUE*TREE_W-1:0] tree_din;
    logic signed [SUM_W-1:0]      tree_sum;
    logic                         tree_vld;

    if ((1 << ADDR_W) > NUM_UNIQUE) begin : g_addr_chk
        assign addr_ok = (int'(coef_addr) < NUM_UNIQUE);
    end else begin : g_addr_all
        assign addr_ok = 1'b1;
    end

    // Coefficient banks: bank_sel names the active bank, the other is the shadow
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bank_sel  <= 1'b0;
            coef_busy <= 1'b0;
            for (int i = 0; i < NUM_UNIQUE; i++) begin
                bank0[i] <= '0;
                bank1[i] <= '0;
            end
        end else begin
            coef_busy <= coef_commit & ~coef_busy;
            if (coef_commit && !coef_busy)
                bank_sel <= ~bank_sel;
            if (coef_we && !coef_busy && addr_ok) begin
                if (bank_sel)
                    bank0[coef_addr] <= coef_wdata;
                else
                    bank1[coef_addr] <= coef_wdata;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_UNIQUE; i++)
            coef_eff[i] = (bank_sel ? bank1[i] : bank0[i]) & coef_mask;
    end

    // p0: delay line
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_p0 <= 1'b0;
            for (int i = 0; i < NUM_TAPS; i++) x_p0[i] <= '0;
        end else begin
            vld_p0 <= in_valid;
            if (in_valid) begin
                x_p0[0] <= x_in;
                for (int i = 1; i < NUM_TAPS; i++) x_p0[i] <= x_p0[i-1];
            end
        end
    end

    // p1: symmetric pre-add
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_p1 <= 1'b0;
            for (int i = 0; i < NUM_UNIQUE; i++) p_p1[i] <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                for (int i = 0; i < CENTRE; i++)
                    p_p1[i] <= P_W'(x_p0[i]) + P_W'(x_p0[NUM_TAPS-1-i]);
                p_p1[CENTRE] <= P_W'(x_p0[CENTRE]);
            end
        end
    end

    // p2: multiply by the active bank as seen on this edge
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_p2 <= 1'b0;
            for (int i = 0; i < NUM_UNIQUE; i++) m_p2[i] <= '0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                for (int i = 0; i < NUM_UNIQUE; i++)
                    m_p2[i] <= PROD_W'(p_p1[i]) * PROD_W'(coef_eff[i]);
            end
        end
    end

    always_comb begin
        tree_din = '0;
        for (int i = 0; i < NUM_UNIQUE; i++)
            tree_din[i*TREE_W +: TREE_W] = scale_narrow(m_p2[i]);
    end

    // p3..: scale register and tree levels live in the tree
    fir_adder_tree #(
        .N (NUM_UNIQUE),
        .W (TREE_W)
    ) u_tree (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_vld    (vld_p2),
        .din       (tree_din),
        .data_mask (data_mask),
        .out_vld   (tree_vld),
        .dout      (tree_sum)
    );

    // Output: saturate, hold y between samples
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            y         <= '0;
            sat_flag  <= 1'b0;
        end else begin
            out_valid <= tree_vld;
            if (tree_vld) begin
                y <= sat_out(tree_sum);
                if (is_sat(tree_sum)) sat_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sym_fir_filt_param.sv
// Bench for sym_fir_filt_param: directed and random stimulus against an arithmetic reference model.
module tb_sym_fir_filt_param;
    import fir_pkg::*;

    localparam int NT = 31;
    localparam int NU = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [17:0] x_in = '0;
    logic [21:0] data_mask = '1;
    logic [17:0] coef_mask = '1;
    logic        coef_we = 1'b0;
    logic [3:0]  coef_addr = '0;
    logic [17:0] coef_wdata = '0;
    logic        coef_commit = 1'b0;
    logic        coef_busy;
    logic        out_valid;
    logic [17:0] y;
    logic        sat_flag;

    always #5 clk = ~clk;

    sym_fir_filt_param dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .x_in        (x_in),
        .data_mask   (data_mask),
        .coef_mask   (coef_mask),
        .coef_we     (coef_we),
        .coef_addr   (coef_addr),
        .coef_wdata  (coef_wdata),
        .coef_commit (coef_commit),
        .coef_busy   (coef_busy),
        .out_valid   (out_valid),
        .y           (y),
        .sat_flag    (sat_flag)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int     cyc = 0;
    int     act_c [NU];
    int     shd_c [NU];
    bit     m_busy = 0;
    int     xh [NT];
    int     pend_w [$];
    int     pend_due [$];
    int     out_due [$];
    longint out_y [$];
    bit     e_vld = 0;
    longint e_y = 0;
    bit     e_sat = 0;

    bit cap_en = 0;
    int cap_y [$];
    int cap_e [$];
    int brick [NU];
    int t1_y [NT];

    task automatic model_edge();
        longint acc, p, c;
        logic signed [17:0] cb;
        bit nb;
        int tmp;
        if (!reset_n) begin
            for (int i = 0; i < NU; i++) begin act_c[i] = 0; shd_c[i] = 0; end
            for (int i = 0; i < NT; i++) xh[i] = 0;
            m_busy = 0;
            pend_w.delete(); pend_due.delete(); out_due.delete(); out_y.delete();
            e_vld = 0; e_y = 0; e_sat = 0;
        end else begin
            // a sample meets the coefficients two edges after it was accepted
            if (pend_due.size() > 0 && pend_due[0] == cyc) begin
                acc = 0;
                for (int i = 0; i < NU; i++) begin
                    if (i < NU - 1) p = longint'(pend_w[i]) + longint'(pend_w[NT-1-i]);
                    else            p = longint'(pend_w[i]);
                    cb = 18'(act_c[i]) & coef_mask;
                    c = cb;
                    acc += (p * c) >>> 17;
                end
                repeat (NT) tmp = pend_w.pop_front();
                tmp = pend_due.pop_front();
                out_due.push_back(cyc + 6);
                out_y.push_back(acc);
            end
            if (coef_we && !m_busy) shd_c[coef_addr] = int'($signed(coef_wdata));
            nb = coef_commit && !m_busy;
            if (nb) begin
                for (int i = 0; i < NU; i++) begin
                    tmp = act_c[i]; act_c[i] = shd_c[i]; shd_c[i] = tmp;
                end
            end
            m_busy = nb;
            if (in_valid) begin
                for (int i = NT - 1; i > 0; i--) xh[i] = xh[i-1];
                xh[0] = int'($signed(x_in));
                for (int i = 0; i < NT; i++) pend_w.push_back(xh[i]);
                pend_due.push_back(cyc + 2);
            end
            e_vld = 0;
            if (out_due.size() > 0 && out_due[0] == cyc) begin
                acc = out_y.pop_front();
                tmp = out_due.pop_front();
                e_vld = 1;
                if (acc > 131071) begin e_y = 131071; e_sat = 1; end
                else if (acc < -131072) begin e_y = -131072; e_sat = 1; end
                else e_y = acc;
            end
        end
        cyc++;
    endtask

    task automatic step(input bit iv, input int xv, input bit we, input int ad, input int wd, input bit cm);
        in_valid    = iv;
        x_in        = 18'(xv);
        coef_we     = we;
        coef_addr   = 4'(ad);
        coef_wdata  = 18'(wd);
        coef_commit = cm;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_val("out_valid", longint'(out_valid), longint'(e_vld));
        check_val("y", longint'($signed(y)), e_y);
        check_val("coef_busy", longint'(coef_busy), longint'(m_busy));
        check_val("sat_flag", longint'(sat_flag), longint'(e_sat));
        if (cap_en && out_valid) begin
            cap_y.push_back(int'($signed(y)));
            cap_e.push_back(cyc - 1);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        idle(n);
        reset_n = 1'b1;
    endtask

    task automatic load_set(input int tbl [NU]);
        for (int i = 0; i < NU; i++) step(0, 0, 1, i, tbl[i], 0);
        step(0, 0, 0, 0, 0, 1);
        idle(1);
    endtask

    task automatic load_const(input int v);
        int tbl [NU];
        for (int i = 0; i < NU; i++) tbl[i] = v;
        load_set(tbl);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int e_imp;
        int xr;
        for (int i = 0; i < NU; i++) brick[i] = int'(FIR_BRICK_COEF[i]);

        // reset state
        do_reset(2);
        check_val("rst_y", longint'($signed(y)), 0);
        check_val("rst_vld", longint'(out_valid), 0);

        // 1: brick-wall impulse response
        load_set(brick);
        cap_y.delete(); cap_e.delete(); cap_en = 1;
        e_imp = cyc;
        step(1, 65536, 0, 0, 0, 0);
        repeat (30) step(1, 0, 0, 0, 0, 0);
        idle(12);
        cap_en = 0;
        check_val("t1_count", cap_y.size(), 31);
        if (cap_y.size() == 31) begin
            check_val("t1_lat", cap_e[0] - e_imp, 8);
            check_val("t1_y0", cap_y[0], -1783);
            check_val("t1_y1", cap_y[1], -2702);
            check_val("t1_y2", cap_y[2], -2057);
            check_val("t1_y3", cap_y[3], 0);
            check_val("t1_peak", cap_y[15], 29705);
            check_val("t1_y29", cap_y[29], -2702);
            check_val("t1_y30", cap_y[30], -1783);
            for (int i = 0; i < NT; i++) t1_y[i] = cap_y[i];
        end

        // 2: DC step, pre-added outer pairs scaled as one product
        load_const(4096);
        repeat (40) step(1, 131071, 0, 0, 0, 0);
        idle(10);
        check_val("t2_dc", longint'($signed(y)), 126960);
        check_val("t2_nosat", longint'(sat_flag), 0);

        // 3: saturation and sticky flag
        load_const(131071);
        repeat (40) step(1, 131071, 0, 0, 0, 0);
        idle(10);
        check_val("t3_sat_y", longint'($signed(y)), 131071);
        check_val("t3_flag", longint'(sat_flag), 1);
        repeat (40) step(1, 0, 0, 0, 0, 0);
        idle(10);
        check_val("t3_y0", longint'($signed(y)), 0);
        check_val("t3_sticky", longint'(sat_flag), 1);

        // 4: sub-rate impulse, one sample every third cycle
        do_reset(1);
        load_set(brick);
        cap_y.delete(); cap_e.delete(); cap_en = 1;
        e_imp = cyc;
        for (int i = 0; i < NT; i++) begin
            step(1, (i == 0) ? 65536 : 0, 0, 0, 0, 0);
            idle(2);
        end
        idle(12);
        cap_en = 0;
        check_val("t4_count", cap_y.size(), 31);
        if (cap_y.size() == 31) begin
            check_val("t4_lat", cap_e[0] - e_imp, 8);
            for (int i = 1; i < NT; i++) check_val("t4_gap", cap_e[i] - cap_e[i-1], 3);
            for (int i = 0; i < NT; i++) check_val("t4_same", cap_y[i], t1_y[i]);
        end

        // 5: mid-stream commit of a zero set; busy-cycle write and commit ignored
        for (int i = 0; i < NU; i++) step(1, int'($urandom_range(0, 262143)) - 131072, 1, i, 0, 0);
        step(1, int'($urandom_range(0, 262143)) - 131072, 0, 0, 0, 1);
        step(1, int'($urandom_range(0, 262143)) - 131072, 1, 15, 50000, 1);
        repeat (20) step(1, int'($urandom_range(0, 262143)) - 131072, 0, 0, 0, 0);
        idle(10);
        check_val("t5_zero", longint'($signed(y)), 0);
        step(0, 0, 0, 0, 0, 1);
        repeat (20) step(1, int'($urandom_range(0, 262143)) - 131072, 0, 0, 0, 0);
        idle(10);

        // 6: reset mid-impulse drops in-flight samples and clears banks
        step(1, 65536, 0, 0, 0, 0);
        repeat (3) step(1, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        step(1, 0, 0, 0, 0, 0);
        check_val("t6_y", longint'($signed(y)), 0);
        check_val("t6_vld", longint'(out_valid), 0);
        reset_n = 1'b1;
        step(1, 65536, 0, 0, 0, 0);
        repeat (30) step(1, 0, 0, 0, 0, 0);
        idle(12);
        check_val("t6_after", longint'($signed(y)), 0);

        // 7: random traffic, coefficient updates and masks
        for (int n = 0; n < 400; n++) begin
            if (n == 200) coef_mask = 18'($urandom);
            if (n == 300) coef_mask = '1;
            xr = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 1) ? 131071 : -131072)
                                              : int'($urandom_range(0, 262143)) - 131072;
            step($urandom_range(0, 1) == 1, xr,
                 $urandom_range(0, 4) == 0, int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 262143)) - 131072,
                 $urandom_range(0, 19) == 0);
        end
        idle(12);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
